// File: rtl/gost89_cfb_stream_ctrl.sv
// gost89_cfb_stream_ctrl
// Block sequencer for one GOST 28147-89 CFB core. It loads the IV gamma, then
// feeds 64-bit blocks from the input stream into the core one at a time. It
// waits for the core to finish and presents each result on the output stream.
// The core is held out of reset for the whole message so its gamma chains
// from block to block.
//
// Ports
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   start, iv, abort      begin a message (iv sampled), synchronous cancel
//   s_valid/s_data/s_last/s_ready   input block stream
//   m_valid/m_data/m_last/m_ready   result block stream
//   core_reset/core_load/core_in    core control and data
//   core_out/core_busy              core result and busy flag
//   busy, done, error, blk_count    status: not idle, end pulse, sticky timeout,
//                                   blocks emitted in the current message
//
// State    | meaning
// ---------+----------------------------------------------------------
// IDLE     | core held in reset, core_in follows iv, waiting for start
// IV       | one cycle of reset with the registered iv on core_in
// WAIT_IN  | core released, accepting the next input block
// LOAD     | one-cycle core_load pulse with the registered block
// RUN      | waiting for core_busy to drop, bounded by TIMEOUT cycles
// OUT      | result presented until the output handshake
module gost89_cfb_stream_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] iv,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [63:0] s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        m_valid,
    output logic [63:0] m_data,
    output logic        m_last,
    input  logic        m_ready,
    output logic        core_reset,
    output logic        core_load,
    output logic [63:0] core_in,
    input  logic [63:0] core_out,
    input  logic        core_busy,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] blk_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IV,
        ST_WAIT_IN,
        ST_LOAD,
        ST_RUN,
        ST_OUT
    } state_t;

    // RUN counter starts at 0; it times out on the TIMEOUT-th busy cycle.
    localparam logic [7:0] RUN_TC = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [63:0] iv_q;
    logic [63:0] data_q;
    logic        last_q;
    logic [63:0] m_data_q;
    logic        m_last_q;
    logic        m_valid_q;
    logic        done_q;
    logic        error_q;
    logic [15:0] blk_cnt_q;
    logic [7:0]  run_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            iv_q      <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            blk_cnt_q <= '0;
            run_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                state_q   <= ST_IDLE;
                m_valid_q <= 1'b0;
                done_q    <= 1'b0 | 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            iv_q      <= iv;
                            blk_cnt_q <= '0;
                            error_q   <= 1'b0;
                            state_q   <= ST_IV;
                        end
                    end
                    ST_IV: state_q <= ST_WAIT_IN;
                    ST_WAIT_IN: begin
                        if (s_valid) begin
                            data_q  <= s_data;
                            last_q  <= s_last;
                            state_q <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        run_cnt_q <= '0;
                        state_q   <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (!core_busy) begin
                            m_data_q  <= core_out;
                            m_last_q  <= last_q;
                            m_valid_q <= 1'b1;
                            state_q   <= ST_OUT;
                        end else if (run_cnt_q == RUN_TC) begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            run_cnt_q <= run_cnt_q + 8'd1;
                        end
                    end
                    ST_OUT: begin
                        if (m_ready) begin
                            m_valid_q <= 1'b0;
                            blk_cnt_q <= blk_cnt_q + 16'd1;
                            if (m_last_q) begin
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_WAIT_IN;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Core data mux: live iv while idle so the core sees it under reset,
    // then the registered iv, then the registered block from WAIT_IN onward.
    always_comb begin
        core_in = data_q;
        case (state_q)
            ST_IDLE: core_in = iv;
            ST_IV:   core_in = iv_q;
            default: ;
        endcase
    end

    assign core_reset = (state_q == ST_IDLE) || (state_q == ST_IV);
    assign core_load  = (state_q == ST_LOAD);
    assign s_ready    = (state_q == ST_WAIT_IN);
    assign busy       = (state_q != ST_IDLE);
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign done       = done_q;
    assign error      = error_q;
    assign blk_count  = blk_cnt_q;

endmodule

// File: tb/tb_gost89_cfb_stream_ctrl.sv
// Directed bench for gost89_cfb_stream_ctrl. A simple core model answers
// core_load with core_in ^ A5.. after a configurable number of busy cycles.
// A second instance with TIMEOUT=8 is used for the timeout sequence.
module tb_gost89_cfb_stream_ctrl;

    localparam logic [63:0] K = 64'hA5A5A5A5A5A5A5A5;

    logic        clk = 1'b0;
    logic        reset_n, start, abort, s_valid, s_last, m_ready;
    logic [63:0] iv, s_data;
    logic [63:0] core_out  = '0;
    logic        core_busy = 1'b0;

    logic        s_ready, m_valid, m_last, core_reset, core_load, busy, done, error;
    logic [63:0] m_data, core_in;
    logic [15:0] blk_count;

    logic        to_s_ready, to_m_valid, to_m_last, to_core_reset, to_core_load;
    logic        to_busy, to_done, to_error;
    logic [63:0] to_m_data, to_core_in;
    logic [15:0] to_blk_count;

    int n_checks = 0;
    int n_fail   = 0;

    gost89_cfb_stream_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .iv(iv), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .core_reset(core_reset), .core_load(core_load), .core_in(core_in),
        .core_out(core_out), .core_busy(core_busy),
        .busy(busy), .done(done), .error(error), .blk_count(blk_count)
    );

    gost89_cfb_stream_ctrl #(.TIMEOUT(8)) u_to (
        .clk(clk), .reset_n(reset_n), .start(start), .iv(iv), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(to_s_ready),
        .m_valid(to_m_valid), .m_data(to_m_data), .m_last(to_m_last), .m_ready(m_ready),
        .core_reset(to_core_reset), .core_load(to_core_load), .core_in(to_core_in),
        .core_out(core_out), .core_busy(core_busy),
        .busy(to_busy), .done(to_done), .error(to_error), .blk_count(to_blk_count)
    );

    always #5 clk = ~clk;

    // Core model: busy for busy_len RUN cycles after the load, or forever when hang.
    int busy_len = 32;
    int rem      = 0;
    bit hang     = 1'b0;
    always @(negedge clk) begin
        if (core_load) begin
            rem       = busy_len;
            core_out  = core_in ^ K;
            core_busy = hang || (rem != 0);
        end else begin
            core_busy = hang || (rem != 0);
            if (rem > 0) rem--;
        end
    end

    // Protocol monitor on the main instance.
    int viol = 0, done_cnt = 0;
    bit done_prev = 1'b0, load_prev = 1'b0;
    always @(negedge clk) begin
        if (core_load && core_reset) viol++;
        if (core_load && load_prev) viol++;
        if (done && done_prev) viol++;
        if (s_ready && m_valid) viol++;
        if (done) done_cnt++;
        done_prev = done;
        load_prev = core_load;
    end

    int cin_bad = 0, stall_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start_msg(input logic [63:0] v);
        iv    = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        iv    = ~v;
        #1;
        chk("iv_registered", core_in, v);
        chk("iv_core_reset", {63'd0, core_reset}, 64'd1);
    endtask

    task automatic send_block(input logic [63:0] d, input logic l, input int stall,
                              input bit poke_start,
                              output logic [63:0] od, output logic ol, output int lat);
        int n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("s_ready_wait", {63'd0, s_ready}, 64'd1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        lat     = 1;
        while (!m_valid && lat < 400) begin
            if (core_in !== d || core_reset !== 1'b0) cin_bad++;
            start = (poke_start && lat == 10);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("m_valid_wait", {63'd0, m_valid}, 64'd1);
        od = m_data;
        ol = m_last;
        repeat (stall) begin
            if (!m_valid || m_data !== od || m_last !== ol || s_ready) stall_bad++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    typedef struct {
        bit          first;
        logic [63:0] iv;
        int          busy_len;
        logic [63:0] d;
        bit          last;
        int          stall;
        logic [63:0] exp_d;
        bit          exp_last;
        logic [15:0] exp_cnt;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] od;
        logic        ol;
        int          lat, d0, early, n;

        vecs[0] = '{1'b1, 64'h0123456789ABCDEF, 32, 64'h0123456789ABCDEF, 1'b0, 0,
                    64'hA486E0C22C0E684A, 1'b0, 16'd1, 35};
        vecs[1] = '{1'b0, 64'h0, 32, 64'h1111111111111111, 1'b0, 0,
                    64'hB4B4B4B4B4B4B4B4, 1'b0, 16'd2, 35};
        vecs[2] = '{1'b0, 64'h0, 32, 64'hFFFFFFFFFFFFFFFF, 1'b1, 0,
                    64'h5A5A5A5A5A5A5A5A, 1'b1, 16'd3, 35};
        vecs[3] = '{1'b1, 64'h0123456789ABCDEF, 32, 64'h0123456789ABCDEF, 1'b0, 0,
                    64'hA486E0C22C0E684A, 1'b0, 16'd1, 35};
        vecs[4] = '{1'b0, 64'h0, 32, 64'h1111111111111111, 1'b0, 10,
                    64'hB4B4B4B4B4B4B4B4, 1'b0, 16'd2, 35};
        vecs[5] = '{1'b0, 64'h0, 32, 64'hFFFFFFFFFFFFFFFF, 1'b1, 0,
                    64'h5A5A5A5A5A5A5A5A, 1'b1, 16'd3, 35};
        vecs[6] = '{1'b1, 64'hCAFEF00D12345678, 0, 64'hA5A5A5A5A5A5A5A5, 1'b1, 0,
                    64'h0000000000000000, 1'b1, 16'd1, 3};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        m_ready = 1'b0; s_data = '0; iv = 64'h0123456789ABCDEF;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_last", {63'd0, m_last}, 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_core_reset", {63'd0, core_reset}, 64'd1);
        chk("rst_core_load", {63'd0, core_load}, 64'd0);
        chk("rst_core_in_iv", core_in, 64'h0123456789ABCDEF);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_blk_count", {48'd0, blk_count}, 64'd0);

        // Table-driven messages
        d0 = 0;
        for (int i = 0; i < 7; i++) begin
            busy_len = vecs[i].busy_len;
            if (vecs[i].first) begin
                d0 = done_cnt;
                start_msg(vecs[i].iv);
            end
            send_block(vecs[i].d, vecs[i].last, vecs[i].stall, 1'b0, od, ol, lat);
            chk($sformatf("v%0d_m_data", i), od, vecs[i].exp_d);
            chk($sformatf("v%0d_m_last", i), {63'd0, ol}, {63'd0, vecs[i].exp_last});
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("v%0d_blk_count", i), {48'd0, blk_count}, {48'd0, vecs[i].exp_cnt});
            if (vecs[i].last) begin
                chk($sformatf("v%0d_done", i), {63'd0, done}, 64'd1);
                chk($sformatf("v%0d_idle", i), {63'd0, busy}, 64'd0);
                repeat (2) @(negedge clk);
                #1;
                chk($sformatf("v%0d_one_done", i), 64'(done_cnt), 64'(d0 + 1));
                chk($sformatf("v%0d_error", i), {63'd0, error}, 64'd0);
            end
        end

        // Abort in RUN of block 2
        busy_len = 32;
        @(negedge clk);
        start_msg(64'hFEDCBA9876543210);
        send_block(64'h1111111111111111, 1'b0, 0, 1'b0, od, ol, lat);
        chk("ab_blk1_data", od, 64'hB4B4B4B4B4B4B4B4);
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ab_s_ready_wait", {63'd0, s_ready}, 64'd1);
        s_valid = 1'b1; s_data = 64'h2222222222222222; s_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("ab_done", {63'd0, done}, 64'd1);
        chk("ab_idle", {63'd0, busy}, 64'd0);
        chk("ab_m_valid", {63'd0, m_valid}, 64'd0);
        chk("ab_blk_count", {48'd0, blk_count}, 64'd1);
        chk("ab_core_reset", {63'd0, core_reset}, 64'd1);
        chk("ab_error", {63'd0, error}, 64'd0);
        @(negedge clk);
        #1;
        chk("ab_done_pulse_end", {63'd0, done}, 64'd0);
        chk("ab_done_count", 64'(done_cnt), 64'(d0 + 1));
        start_msg(64'h0F0F0F0F0F0F0F0F);
        send_block(64'hA5A5A5A5A5A5A5A5, 1'b1, 0, 1'b0, od, ol, lat);
        chk("ab_restart_data", od, 64'h0);
        chk("ab_restart_cnt", {48'd0, blk_count}, 64'd1);

        // Start ignored during RUN, then reset during OUT
        @(negedge clk);
        start_msg(64'h0123456789ABCDEF);
        send_block(64'h0000000000000000, 1'b0, 0, 1'b1, od, ol, lat);
        chk("sr_blk1_data", od, 64'hA5A5A5A5A5A5A5A5);
        chk("sr_blk_count", {48'd0, blk_count}, 64'd1);
        chk("sr_still_busy", {63'd0, busy}, 64'd1);
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("sr_s_ready_wait", {63'd0, s_ready}, 64'd1);
        s_valid = 1'b1; s_data = 64'hFFFFFFFFFFFFFFFF; s_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        n = 0;
        while (!m_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("sr_m_valid_wait", {63'd0, m_valid}, 64'd1);
        chk("sr_blk2_data", m_data, 64'h5A5A5A5A5A5A5A5A);
        #2;
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("sr_rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("sr_rst_m_data", m_data, 64'd0);
        chk("sr_rst_busy", {63'd0, busy}, 64'd0);
        chk("sr_rst_blk_count", {48'd0, blk_count}, 64'd0);
        chk("sr_rst_core_reset", {63'd0, core_reset}, 64'd1);
        chk("sr_rst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("sr_no_done", 64'(done_cnt), 64'(d0));
        chk("sr_stays_idle", {63'd0, busy}, 64'd0);

        // Timeout on the TIMEOUT=8 instance with a core that never finishes
        hang = 1'b1;
        start_msg(64'h1122334455667788);
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        s_valid = 1'b1; s_data = 64'h3333333333333333; s_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        n = 0;
        while (!to_core_load && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_load_seen", {63'd0, to_core_load}, 64'd1);
        early = 0;
        repeat (8) begin
            @(negedge clk);
            if (to_done) early++;
        end
        chk("to_no_early_done", 64'(early), 64'd0);
        @(negedge clk);
        #1;
        chk("to_done", {63'd0, to_done}, 64'd1);
        chk("to_error", {63'd0, to_error}, 64'd1);
        chk("to_idle", {63'd0, to_busy}, 64'd0);
        chk("to_core_reset", {63'd0, to_core_reset}, 64'd1);
        @(negedge clk);
        #1;
        chk("to_done_end", {63'd0, to_done}, 64'd0);
        chk("to_error_sticky", {63'd0, to_error}, 64'd1);
        chk("main_no_error", {63'd0, error}, 64'd0);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        hang  = 1'b0;
        #1;
        chk("main_abort_idle", {63'd0, busy}, 64'd0);

        repeat (3) @(negedge clk);
        chk("protocol_violations", 64'(viol), 64'd0);
        chk("core_in_during_run", 64'(cin_bad), 64'd0);
        chk("stall_stability", 64'(stall_bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
